// File: rtl/audio_seq_pkg.sv
// Shared types and write-data select priority for the stereo filter sequencer.
package audio_seq_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_FILT   = 3'd2,
    S_SETTLE = 3'd3,
    S_WAITW  = 3'd4,
    S_WRITE  = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    WSEL_ZERO = 2'd0,
    WSEL_RAW  = 2'd1,
    WSEL_FILT = 2'd2
  } wr_sel_t;

  // Muting during warm-up outranks bypass; bypass outranks the filtered sum.
  function automatic wr_sel_t write_select(input logic mute_warmup,
                                           input logic warm,
                                           input logic bypass);
    wr_sel_t sel;
    if (mute_warmup && !warm) begin
      sel = WSEL_ZERO;
    end else if (bypass) begin
      sel = WSEL_RAW;
    end else begin
      sel = WSEL_FILT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/audio_filter_sequencer_warmup.sv
// Saturating count of filter enables; warm goes high once the window is full.
module warmup_counter #(
  parameter int N = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic warm
);

  localparam logic [N:0] FULL = {1'b1, {N{1'b0}}};

  logic [N:0] count_q, count_d;
  logic       warm_q, warm_d;

  // Next count, held at FULL once the window has been filled.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != FULL)) begin
      count_d = count_q + (N+1)'(1);
    end else begin
      count_d = count_q;
    end
    warm_d = (count_d == FULL);
  end

  // Count and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      warm_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      warm_q  <= warm_d;
    end
  end

  assign warm = warm_q;

endmodule

// File: rtl/audio_filter_sequencer.sv
// Moore sequencer between the codec FIFOs and the two per-channel moving-average filters.
module audio_filter_sequencer
  import audio_seq_pkg::*;
#(
  parameter int N = 5,
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         read_ready,
  input  logic         write_ready,
  input  logic [W-1:0] readdata_left,
  input  logic [W-1:0] readdata_right,
  output logic         read,
  output logic         write,
  output logic [W-1:0] writedata_left,
  output logic [W-1:0] writedata_right,
  output logic         filt_en,
  output logic [W-1:0] filt_in_left,
  output logic [W-1:0] filt_in_right,
  input  logic [W-1:0] filt_out_left,
  input  logic [W-1:0] filt_out_right,
  input  logic         bypass,
  input  logic         mute_warmup,
  output logic         busy,
  output logic         warm,
  output logic [31:0]  sample_count,
  output logic [15:0]  stall_count
);

  seq_state_t  state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        filt_en_q, filt_en_d;
  logic        busy_q, busy_d;
  logic [W-1:0] filt_in_left_q, filt_in_left_d;
  logic [W-1:0] filt_in_right_q, filt_in_right_d;
  logic [W-1:0] writedata_left_q, writedata_left_d;
  logic [W-1:0] writedata_right_q, writedata_right_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  warmup_counter #(.N(N)) u_warmup (
    .clk   (clk),
    .reset (reset),
    .inc   (filt_en_q),
    .warm  (warm)
  );

  // Next-state, capture and counter logic; strobes are decoded from the next state.
  always_comb begin
    state_d           = state_q;
    filt_in_left_d    = filt_in_left_q;
    filt_in_right_d   = filt_in_right_q;
    writedata_left_d  = writedata_left_q;
    writedata_right_d = writedata_right_q;
    sample_count_d    = sample_count_q;
    stall_count_d     = stall_count_q;
    case (state_q)
      S_IDLE: begin
        if (read_ready) begin
          state_d         = S_READ;
          filt_in_left_d  = readdata_left;
          filt_in_right_d = readdata_right;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:   state_d = S_FILT;
      S_FILT:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_WAITW;
      S_WAITW: begin
        if (write_ready) begin
          state_d = S_WRITE;
          case (write_select(mute_warmup, warm, bypass))
            WSEL_RAW: begin
              writedata_left_d  = filt_in_left_q;
              writedata_right_d = filt_in_right_q;
            end
            WSEL_FILT: begin
              writedata_left_d  = filt_out_left;
              writedata_right_d = filt_out_right;
            end
            default: begin
              writedata_left_d  = {W{1'b0}};
              writedata_right_d = {W{1'b0}};
            end
          endcase
        end else if (stall_count_q != 16'hFFFF) begin
          stall_count_d = stall_count_q + 16'd1;
        end else begin
          stall_count_d = stall_count_q;
        end
      end
      S_WRITE: begin
        state_d        = S_IDLE;
        sample_count_d = sample_count_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    read_d    = (state_d == S_READ);
    filt_en_d = (state_d == S_FILT);
    write_d   = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      read_q            <= 1'b0;
      write_q           <= 1'b0;
      filt_en_q         <= 1'b0;
      busy_q            <= 1'b0;
      filt_in_left_q    <= '0;
      filt_in_right_q   <= '0;
      writedata_left_q  <= '0;
      writedata_right_q <= '0;
      sample_count_q    <= 32'd0;
      stall_count_q     <= 16'd0;
    end else begin
      state_q           <= state_d;
      read_q            <= read_d;
      write_q           <= write_d;
      filt_en_q         <= filt_en_d;
      busy_q            <= busy_d;
      filt_in_left_q    <= filt_in_left_d;
      filt_in_right_q   <= filt_in_right_d;
      writedata_left_q  <= writedata_left_d;
      writedata_right_q <= writedata_right_d;
      sample_count_q    <= sample_count_d;
      stall_count_q     <= stall_count_d;
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign filt_en         = filt_en_q;
  assign busy            = busy_q;
  assign filt_in_left    = filt_in_left_q;
  assign filt_in_right   = filt_in_right_q;
  assign writedata_left  = writedata_left_q;
  assign writedata_right = writedata_right_q;
  assign sample_count    = sample_count_q;
  assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_audio_filter_sequencer.sv
// Directed bench for audio_filter_sequencer with a behavioural 8-tap running-sum filter pair.
module tb_audio_filter_sequencer;

  localparam int N = 3;
  localparam int W = 24;

  logic         clk;
  logic         reset;
  logic         read_ready, write_ready;
  logic [W-1:0] readdata_left, readdata_right;
  logic         read, write, filt_en;
  logic [W-1:0] writedata_left, writedata_right;
  logic [W-1:0] filt_in_left, filt_in_right;
  logic [W-1:0] filt_out_left, filt_out_right;
  logic         bypass, mute_warmup;
  logic         busy, warm;
  logic [31:0]  sample_count;
  logic [15:0]  stall_count;

  int n_cmp;
  int n_bad;

  audio_filter_sequencer #(.N(N), .W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .filt_en         (filt_en),
    .filt_in_left    (filt_in_left),
    .filt_in_right   (filt_in_right),
    .filt_out_left   (filt_out_left),
    .filt_out_right  (filt_out_right),
    .bypass          (bypass),
    .mute_warmup     (mute_warmup),
    .busy            (busy),
    .warm            (warm),
    .sample_count    (sample_count),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running sum over the last 2**N enabled inputs, one per channel.
  logic [W-1:0] hist_l [0:7];
  logic [W-1:0] hist_r [0:7];
  logic [W-1:0] sum_l, sum_r;

  always @(posedge clk) begin
    if (!reset) begin
      sum_l <= '0;
      sum_r <= '0;
      for (int i = 0; i < 8; i++) begin
        hist_l[i] <= '0;
        hist_r[i] <= '0;
      end
    end else if (filt_en) begin
      sum_l <= sum_l + filt_in_left - hist_l[7];
      sum_r <= sum_r + filt_in_right - hist_r[7];
      hist_l[0] <= filt_in_left;
      hist_r[0] <= filt_in_right;
      for (int i = 1; i < 8; i++) begin
        hist_l[i] <= hist_l[i-1];
        hist_r[i] <= hist_r[i-1];
      end
    end
  end

  assign filt_out_left  = sum_l;
  assign filt_out_right = sum_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    read_ready  = 1'b0;
    write_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({busy, read, write, filt_en, warm} !== 5'b00000) begin
      $display("FAIL reset_flags: got %b want 00000", {busy, read, write, filt_en, warm});
      n_bad++;
    end
    n_cmp++;
    if (sample_count !== 32'd0) begin
      $display("FAIL reset_sample_count: got %0d want 0", sample_count);
      n_bad++;
    end
    n_cmp++;
    if (stall_count !== 16'd0) begin
      $display("FAIL reset_stall_count: got %0d want 0", stall_count);
      n_bad++;
    end
  endtask

  task automatic test_warmup();
    int nw;
    logic [W-1:0] exp_l, exp_r;
    do_reset();
    mute_warmup    = 1'b1;
    bypass         = 1'b0;
    readdata_left  = 24'd8;
    readdata_right = 24'hFFFFF8;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    nw = 0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (write) begin
        exp_l = (nw < 7) ? 24'd0 : 24'd64;
        exp_r = (nw < 7) ? 24'd0 : 24'hFFFFC0;
        n_cmp++;
        if (writedata_left !== exp_l || writedata_right !== exp_r) begin
          $display("FAIL warmup_write%0d: got %h/%h want %h/%h", nw + 1,
                   writedata_left, writedata_right, exp_l, exp_r);
          n_bad++;
        end
        nw++;
      end
      if (c == 44) begin
        n_cmp++;
        if (warm !== 1'b0) begin
          $display("FAIL warm_early: got %b want 0 at 8th filt_en cycle", warm);
          n_bad++;
        end
      end
      if (c == 45) begin
        n_cmp++;
        if (warm !== 1'b1) begin
          $display("FAIL warm_rise: got %b want 1 after 8th filt_en", warm);
          n_bad++;
        end
      end
      read_ready = (c < 43);
    end
    n_cmp++;
    if (nw !== 8) begin
      $display("FAIL warmup_write_count: got %0d want 8", nw);
      n_bad++;
    end
  endtask

  task automatic test_reset_midwait();
    int pulses;
    read_ready  = 1'b1;
    write_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      read_ready = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL midwait_busy_before: got %b want 1", busy);
      n_bad++;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if ({busy, read, write, filt_en, warm} !== 5'b00000) begin
      $display("FAIL midwait_flags: got %b want 00000", {busy, read, write, filt_en, warm});
      n_bad++;
    end
    n_cmp++;
    if (sample_count !== 32'd0 || stall_count !== 16'd0) begin
      $display("FAIL midwait_counters: got %0d/%0d want 0/0", sample_count, stall_count);
      n_bad++;
    end
    write_ready = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (read || write || filt_en || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      $display("FAIL midwait_activity: got %0d active cycles want 0", pulses);
      n_bad++;
    end
  endtask

  task automatic test_single();
    int rc, fc, wc;
    logic [W-1:0] wl, wr;
    do_reset();
    bypass         = 1'b1;
    mute_warmup    = 1'b0;
    readdata_left  = 24'h000123;
    readdata_right = 24'hFFFF00;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    rc = -1; fc = -1; wc = -1;
    wl = '0; wr = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      read_ready = 1'b0;
      if (read && rc < 0) rc = c;
      if (filt_en && fc < 0) fc = c;
      if (write && wc < 0) begin
        wc = c;
        wl = writedata_left;
        wr = writedata_right;
      end
    end
    n_cmp++;
    if (rc !== 1 || fc !== 2 || wc !== 5) begin
      $display("FAIL single_timing: got read/filt/write %0d/%0d/%0d want 1/2/5", rc, fc, wc);
      n_bad++;
    end
    n_cmp++;
    if (wl !== 24'h000123 || wr !== 24'hFFFF00) begin
      $display("FAIL single_bypass_data: got %h/%h want 000123/ffff00", wl, wr);
      n_bad++;
    end
    n_cmp++;
    if (filt_in_left !== 24'h000123 || filt_in_right !== 24'hFFFF00) begin
      $display("FAIL single_capture: got %h/%h want 000123/ffff00", filt_in_left, filt_in_right);
      n_bad++;
    end
    n_cmp++;
    if (sample_count !== 32'd1) begin
      $display("FAIL single_sample_count: got %0d want 1", sample_count);
      n_bad++;
    end
  endtask

  task automatic test_backpressure();
    int reads, writes, wc;
    do_reset();
    bypass      = 1'b1;
    read_ready  = 1'b1;
    write_ready = 1'b0;
    reads = 0; writes = 0; wc = -1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (read) reads++;
      if (write) begin
        writes++;
        wc = c;
      end
      write_ready = (c >= 24);
      read_ready  = (c < 26);
    end
    n_cmp++;
    if (stall_count !== 16'd20) begin
      $display("FAIL bp_stall_count: got %0d want 20", stall_count);
      n_bad++;
    end
    n_cmp++;
    if (writes !== 1 || wc !== 25) begin
      $display("FAIL bp_write: got %0d writes at cycle %0d want 1 at 25", writes, wc);
      n_bad++;
    end
    n_cmp++;
    if (reads !== 1) begin
      $display("FAIL bp_reads: got %0d want 1 before write completes", reads);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int reads, filts, writes, pos_bad, overlap;
    logic exp_r, exp_f, exp_w;
    do_reset();
    read_ready  = 1'b1;
    write_ready = 1'b1;
    reads = 0; filts = 0; writes = 0; pos_bad = 0; overlap = 0;
    for (int c = 1; c <= 62; c++) begin
      tick();
      exp_r = ((c % 6) == 1) && (c <= 55);
      exp_f = ((c % 6) == 2) && (c <= 56);
      exp_w = ((c % 6) == 5) && (c <= 59);
      if (read !== exp_r || filt_en !== exp_f || write !== exp_w) pos_bad++;
      if ((int'(read) + int'(filt_en) + int'(write)) > 1) overlap++;
      if (read) reads++;
      if (filt_en) filts++;
      if (write) writes++;
      read_ready = (c < 55);
    end
    n_cmp++;
    if (reads !== 10 || filts !== 10 || writes !== 10) begin
      $display("FAIL b2b_counts: got %0d/%0d/%0d want 10/10/10", reads, filts, writes);
      n_bad++;
    end
    n_cmp++;
    if (pos_bad !== 0) begin
      $display("FAIL b2b_period: got %0d misplaced cycles want 0", pos_bad);
      n_bad++;
    end
    n_cmp++;
    if (overlap !== 0) begin
      $display("FAIL b2b_overlap: got %0d overlapping cycles want 0", overlap);
      n_bad++;
    end
    n_cmp++;
    if (sample_count !== 32'd10) begin
      $display("FAIL b2b_sample_count: got %0d want 10", sample_count);
      n_bad++;
    end
  endtask

  task automatic test_saturation();
    int got;
    do_reset();
    read_ready  = 1'b1;
    write_ready = 1'b0;
    tick();
    read_ready = 1'b0;
    repeat (70000) tick();
    n_cmp++;
    if (stall_count !== 16'hFFFF) begin
      $display("FAIL sat_stall: got %h want ffff", stall_count);
      n_bad++;
    end
    repeat (5) tick();
    n_cmp++;
    if (stall_count !== 16'hFFFF || busy !== 1'b1) begin
      $display("FAIL sat_hold: got stall %h busy %b want ffff 1", stall_count, busy);
      n_bad++;
    end
    write_ready = 1'b1;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (write) got++;
    end
    n_cmp++;
    if (got !== 1 || sample_count !== 32'd1) begin
      $display("FAIL sat_release: got %0d writes count %0d want 1 1", got, sample_count);
      n_bad++;
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b0;
    read_ready     = 1'b0;
    write_ready    = 1'b0;
    readdata_left  = '0;
    readdata_right = '0;
    bypass         = 1'b0;
    mute_warmup    = 1'b0;
    tick();
    test_reset();
    test_warmup();
    test_reset_midwait();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_filter_sequencer.md
Name: audio_filter_sequencer

Overview:
Sequences the stereo moving-average filter datapath against the codec FIFO handshake. On each sample it captures left/right from the codec and strobes a one-cycle enable to the two per-channel filter instances. It waits for the filter sum to settle, then writes the filtered (or bypassed/muted) result back to the codec. It sits between the audio codec interface and the filter instances and replaces ad-hoc en/read/write wiring.

Parameters:
N, 5, log2 of filter window depth; warm-up length is 2**N samples
W, 24, sample width in bits (signed)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
read_ready  in  1  codec input FIFO has a sample pair
write_ready  in  1  codec output FIFO can accept a sample pair
readdata_left  in  W  codec input sample, left
readdata_right  in  W  codec input sample, right
read  out  1  one-cycle pop of codec input FIFO
write  out  1  one-cycle push to codec output FIFO
writedata_left  out  W  sample to codec, left
writedata_right  out  W  sample to codec, right
filt_en  out  1  one-cycle enable to both filter instances
filt_in_left  out  W  filter input, left (held capture register)
filt_in_right  out  W  filter input, right
filt_out_left  in  W  filter running-sum output, left
filt_out_right  in  W  filter running-sum output, right
bypass  in  1  1 = write raw captured samples instead of filter output
mute_warmup  in  1  1 = write zero until filter window is full
busy  out  1  high in every state except S_IDLE
warm  out  1  window full (2**N enables issued since reset)
sample_count  out  32  completed write handshakes, wraps at 2**32
stall_count  out  16  cycles spent in S_WAITW, saturates at 16'hFFFF

Behaviour:
- All outputs are registered (Moore). Reset (reset==0 at posedge) forces S_IDLE, clears all outputs, capture registers, warm-up counter, sample_count and stall_count. Reset applies mid-transaction too: any in-flight sample is abandoned with no read, write or filt_en issued after the reset edge.
- States: S_IDLE, S_READ, S_FILT, S_SETTLE, S_WAITW, S_WRITE.
- S_IDLE: if read_ready=1, latch readdata_* into filt_in_* and go to S_READ; otherwise stay.
- S_READ: read=1 for exactly this cycle; go to S_FILT.
- S_FILT: filt_en=1 for exactly this cycle; increment warm-up counter (saturating at 2**N); go to S_SETTLE.
- S_SETTLE: one cycle for the filter sum register to update; go to S_WAITW.
- S_WAITW: if write_ready=1, latch writedata_* and go to S_WRITE; otherwise stay and increment stall_count (saturating).
- Write-data select, evaluated at the S_WAITW latch cycle, priority order:
  - mute_warmup=1 and warm=0 -> 0
  - else bypass=1 -> filt_in_*
  - else -> filt_out_*
- S_WRITE: write=1 for exactly this cycle; sample_count+1; go to S_IDLE.
- Minimum latency from read_ready seen in S_IDLE to the write pulse is 5 cycles with write_ready held high. Minimum period is 6 cycles per sample.
- read, write and filt_en are never high in the same cycle, and each pulses exactly once per sample.
- read_ready is ignored outside S_IDLE (the codec FIFO buffers it). write_ready is ignored outside S_WAITW.
- warm rises in the cycle after the 2**N-th filt_en and stays high until reset.
- bypass and mute_warmup may change at any time; only their value at the latch cycle matters.
- Signed values pass through unmodified; no arithmetic on samples in this block.

Decomposition:
- Shared package audio_seq_pkg:
  - state enum type seq_state_t
  - localparam SAMPLE_W = 24
  - write-select priority encoded as a function
- One sub-module, warmup_counter (parameter N): saturating counter with a warm flag, incremented by filt_en and cleared by reset.
- The sequencer instantiates warmup_counter; both filter instances live in the parent.

Test Plan:
- Reset mid-S_WAITW:
  - write_ready=0, then reset=0 for one cycle.
  - Required: next cycle state S_IDLE, busy=0, no write pulse, counters 0.
- Single sample, bypass=1, mute_warmup=0, readdata_left=24'h000123, readdata_right=24'hFFFF00, write_ready=1:
  - read pulse at cycle 1, filt_en at cycle 2, write at cycle 5.
  - writedata = 24'h000123 / 24'hFFFF00.
  - sample_count=1.
- Warm-up with N=3, mute_warmup=1, constant input 8, paired with real filter instances:
  - Writes 1-7 output 0.
  - warm=1 after the 8th filt_en; the 8th write outputs the filter sum.
- Backpressure:
  - write_ready held 0 for 20 cycles in S_WAITW, then 1.
  - stall_count=20, exactly one write pulse, no second read until the write completes.
- Back-to-back, read_ready and write_ready held 1 for 10 samples:
  - exactly 10 read, 10 filt_en and 10 write pulses, one every 6 cycles.
  - Never two of them in the same cycle.
- Saturation: force 70000 stall cycles -> stall_count holds 16'hFFFF and does not wrap.
